// File: rtl/wb_regfile.sv
// Writeback-stage architectural state: 32-entry GPR file with r0 tied to zero, plus HI/LO.
// Optional feature macro WB_RETIRE_CNT_EN enables a saturating writeback (retire) counter.
module wb_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re1_i,
   input  logic [ADDR_W-1:0] raddr1_i,
   output logic [DATA_W-1:0] rdata1_o,
   input  logic              re2_i,
   input  logic [ADDR_W-1:0] raddr2_i,
   output logic [DATA_W-1:0] rdata2_o,
   input  logic              whilo_i,
   input  logic [DATA_W-1:0] hi_i,
   input  logic [DATA_W-1:0] lo_i,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o,
   output logic [CNT_W-1:0]  retire_cnt_o
);

   localparam int NREG = 2 ** ADDR_W;

   logic [DATA_W-1:0] gpr_q [NREG];
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic              gprWr;

   assign gprWr = we_i && (waddr_i != '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NREG; i++) begin
            gpr_q[i] <= '0;
         end
      end else if (gprWr) begin
         gpr_q[waddr_i] <= wdata_i;
      end
   end

   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (whilo_i) begin
         hi_d = hi_i;
         lo_d = lo_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         hi_q <= '0;
         lo_q <= '0;
      end else begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end

   // Forward the in-flight write so ID never reads a stale operand.
   always_comb begin
      rdata1_o = '0;
      if (rst_ni && re1_i && (raddr1_i != '0)) begin
         if (we_i && (waddr_i == raddr1_i)) begin
            rdata1_o = wdata_i;
         end else begin
            rdata1_o = gpr_q[raddr1_i];
         end
      end
   end

   always_comb begin
      rdata2_o = '0;
      if (rst_ni && re2_i && (raddr2_i != '0)) begin
         if (we_i && (waddr_i == raddr2_i)) begin
            rdata2_o = wdata_i;
         end else begin
            rdata2_o = gpr_q[raddr2_i];
         end
      end
   end

   // HI/LO are not bypassed here; EX forwards from MEM/WB itself.
   assign hi_o = rst_ni ? hi_q : '0;
   assign lo_o = rst_ni ? lo_q : '0;

`ifdef WB_RETIRE_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if ((gprWr || whilo_i) && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign retire_cnt_o = cnt_q;
`else
   assign retire_cnt_o = '0;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: array-based reference model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_wb_regfile;

   logic        clk_i;
   logic        rst_ni;
   logic        we_i;
   logic [4:0]  waddr_i;
   logic [31:0] wdata_i;
   logic        re1_i;
   logic [4:0]  raddr1_i;
   logic [31:0] rdata1_o;
   logic        re2_i;
   logic [4:0]  raddr2_i;
   logic [31:0] rdata2_o;
   logic        whilo_i;
   logic [31:0] hi_i;
   logic [31:0] lo_i;
   logic [31:0] hi_o;
   logic [31:0] lo_o;
   logic [3:0]  retire_cnt_o;

   int testsRun    = 0;
   int testsFailed = 0;
   bit done        = 0;

   logic [31:0] modelGpr [32] = '{default: 32'h0};
   logic [31:0] modelHi  = 32'h0;
   logic [31:0] modelLo  = 32'h0;
   int          modelCnt = 0;

   wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .we_i        (we_i),
      .waddr_i     (waddr_i),
      .wdata_i     (wdata_i),
      .re1_i       (re1_i),
      .raddr1_i    (raddr1_i),
      .rdata1_o    (rdata1_o),
      .re2_i       (re2_i),
      .raddr2_i    (raddr2_i),
      .rdata2_o    (rdata2_o),
      .whilo_i     (whilo_i),
      .hi_i        (hi_i),
      .lo_i        (lo_i),
      .hi_o        (hi_o),
      .lo_o        (lo_o),
      .retire_cnt_o(retire_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Reference model: architectural state updated from the writeback rules.
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 32; i++) modelGpr[i] = 32'h0;
         modelHi  = 32'h0;
         modelLo  = 32'h0;
         modelCnt = 0;
      end else begin
         if (we_i && waddr_i != 5'd0) modelGpr[waddr_i] = wdata_i;
         if (whilo_i) begin
            modelHi = hi_i;
            modelLo = lo_i;
         end
         if ((we_i && waddr_i != 5'd0) || whilo_i) modelCnt++;
      end
   end

   function automatic logic [31:0] expRead(input logic en, input logic [4:0] addr);
      if (!rst_ni || !en || addr == 5'd0) return 32'h0;
      if (we_i && waddr_i == addr) return wdata_i;
      return modelGpr[addr];
   endfunction

   function automatic logic [31:0] expCnt();
`ifdef WB_RETIRE_CNT_EN
      return (modelCnt > 15) ? 32'd15 : 32'(modelCnt);
`else
      return 32'h0;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk_i) begin
      if (!done) begin
         checkOutput("model rdata1", rdata1_o, expRead(re1_i, raddr1_i));
         checkOutput("model rdata2", rdata2_o, expRead(re2_i, raddr2_i));
         checkOutput("model hi_o", hi_o, rst_ni ? modelHi : 32'h0);
         checkOutput("model lo_o", lo_o, rst_ni ? modelLo : 32'h0);
         checkOutput("model retire_cnt", {28'h0, retire_cnt_o}, expCnt());
      end
   end

   task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic re1, input logic [4:0] ra1,
                                input logic re2, input logic [4:0] ra2,
                                input logic whilo, input logic [31:0] hi,
                                input logic [31:0] lo);
      we_i     = we;
      waddr_i  = wa;
      wdata_i  = wd;
      re1_i    = re1;
      raddr1_i = ra1;
      re2_i    = re2;
      raddr2_i = ra2;
      whilo_i  = whilo;
      hi_i     = hi;
      lo_i     = lo;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   initial begin
      rst_ni = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1 rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #2 rst_ni = 1'b1;

      // Every register reads zero after reset on both ports.
      for (int a = 0; a < 32; a++) begin
         applyStimulus(0, 0, 0, 1, 5'(a), 1, 5'(31 - a), 0, 0, 0);
         #1;
         checkOutput("reset rdata1", rdata1_o, 32'h0);
         checkOutput("reset rdata2", rdata2_o, 32'h0);
      end
      checkOutput("reset hi_o", hi_o, 32'h0);
      checkOutput("reset lo_o", lo_o, 32'h0);
      checkOutput("reset retire_cnt", {28'h0, retire_cnt_o}, 32'h0);
      tick();

      // Same-cycle bypass, then the array copy.
      applyStimulus(1, 5, 32'h1234_5678, 1, 5, 1, 5, 0, 0, 0);
      #1;
      checkOutput("bypass rdata1", rdata1_o, 32'h1234_5678);
      checkOutput("bypass rdata2", rdata2_o, 32'h1234_5678);
      tick();
      applyStimulus(0, 0, 0, 1, 5, 0, 0, 0, 0, 0);
      #1;
      checkOutput("array rdata1", rdata1_o, 32'h1234_5678);
      tick();

      // Writes to r0 are dropped and do not count.
      applyStimulus(1, 0, 32'hFFFF_FFFF, 1, 0, 1, 0, 0, 0, 0);
      #1;
      checkOutput("r0 bypass rdata1", rdata1_o, 32'h0);
      checkOutput("r0 bypass rdata2", rdata2_o, 32'h0);
      tick();
      applyStimulus(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
      #1;
      checkOutput("r0 after rdata1", rdata1_o, 32'h0);
`ifdef WB_RETIRE_CNT_EN
      checkOutput("r0 retire_cnt", {28'h0, retire_cnt_o}, 32'd1);
`else
      checkOutput("r0 retire_cnt", {28'h0, retire_cnt_o}, 32'd0);
`endif
      tick();

      // HI/LO update only after the edge and hold afterwards.
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'hA5A5_0001, 32'h5A5A_0002);
      #1;
      checkOutput("hilo pre hi_o", hi_o, 32'h0);
      checkOutput("hilo pre lo_o", lo_o, 32'h0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'h1111_1111, 32'h2222_2222);
      #1;
      checkOutput("hilo post hi_o", hi_o, 32'hA5A5_0001);
      checkOutput("hilo post lo_o", lo_o, 32'h5A5A_0002);
      tick();
      #1;
      checkOutput("hilo held hi_o", hi_o, 32'hA5A5_0001);
      checkOutput("hilo held lo_o", lo_o, 32'h5A5A_0002);

      // Mixed bypass and array reads on the two ports.
      applyStimulus(1, 7, 32'hDEAD_BEEF, 1, 7, 1, 5, 0, 0, 0);
      #1;
      checkOutput("mix bypass rdata1", rdata1_o, 32'hDEAD_BEEF);
      checkOutput("mix array rdata2", rdata2_o, 32'h1234_5678);
      tick();
      applyStimulus(1, 5, 32'hCAFE_F00D, 1, 5, 1, 5, 0, 0, 0);
      #1;
      checkOutput("overwrite rdata1", rdata1_o, 32'hCAFE_F00D);
      checkOutput("overwrite rdata2", rdata2_o, 32'hCAFE_F00D);
      tick();
      applyStimulus(1, 9, 32'h0BAD_0BAD, 1, 7, 0, 9, 0, 0, 0);
      #1;
      checkOutput("readback r7", rdata1_o, 32'hDEAD_BEEF);
      checkOutput("disabled bypass rdata2", rdata2_o, 32'h0);
      tick();

      // Disabled port reads zero; async reset clears outputs without a clock.
      applyStimulus(0, 0, 0, 1, 5, 0, 5, 0, 0, 0);
      #1;
      checkOutput("re2 off rdata2", rdata2_o, 32'h0);
      checkOutput("re1 on rdata1", rdata1_o, 32'hCAFE_F00D);
      rst_ni = 1'b0;
      #1;
      checkOutput("async rst rdata1", rdata1_o, 32'h0);
      checkOutput("async rst hi_o", hi_o, 32'h0);
      checkOutput("async rst lo_o", lo_o, 32'h0);
      applyStimulus(1, 5, 32'h7777_7777, 1, 5, 0, 0, 1, 32'h3, 32'h4);
      tick();
      applyStimulus(0, 0, 0, 1, 5, 1, 9, 0, 0, 0);
      rst_ni = 1'b1;
      #1;
      checkOutput("post rst r5", rdata1_o, 32'h0);
      checkOutput("post rst r9", rdata2_o, 32'h0);
      checkOutput("post rst hi_o", hi_o, 32'h0);
      tick();

      // Twenty writebacks drive the 4-bit counter into saturation.
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1, 5'((i % 31) + 1), 32'(i * 3 + 1), 1, 5'((i % 31) + 1), 1, 5'(i % 31),
                       0, 0, 0);
         tick();
      end
      applyStimulus(0, 0, 0, 1, 20, 1, 3, 0, 0, 0);
      #1;
      checkOutput("last write r20", rdata1_o, 32'd58);
      checkOutput("early write r3", rdata2_o, 32'd7);
`ifdef WB_RETIRE_CNT_EN
      checkOutput("saturated retire_cnt", {28'h0, retire_cnt_o}, 32'hF);
`else
      checkOutput("absent retire_cnt", {28'h0, retire_cnt_o}, 32'h0);
`endif
      tick();

      done = 1'b1;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
